fir_filter_stage_k_pow2: RTL and testbench
==========================================

# fir_filter_stage_k_pow2

Single-pole low-pass smoothing stage with a power-of-two coefficient: y += (x − y)·2^-SHIFT, implemented multiplier-free with shifts and adds. It sits in the theremin sensor chain after period measurement and smooths the raw 32-bit measurement stream. It runs on the system clock and uses an external PHASE strobe that splits each update into two clock cycles. Several instances can be cascaded, each driven by the same PHASE.

## Interface
- DATA_WIDTH, 32, width of input and output samples (unsigned).
- SHIFT, 8, coefficient exponent (k = 2^-SHIFT). Legal range 1..16.

- CLK  in  1  system clock; all logic updates on the rising edge.
- RESET  in  1  synchronous, active-low reset: 0 = reset, sampled on the rising CLK edge.
- PHASE  in  1  phase strobe, sampled on CLK; nominally alternates 1,0,1,0.
- IN_VALUE  in  DATA_WIDTH  unsigned input sample.
- OUT_VALUE  out  DATA_WIDTH  unsigned filtered output, registered.

## Operation
- Internal state:
  - acc: DATA_WIDTH+SHIFT bits, unsigned. Holds y scaled by 2^SHIFT.
  - in_reg: DATA_WIDTH bits.
  - part: DATA_WIDTH+SHIFT bits.
  - pend: 1-bit pending flag.
- Recurrence: acc_next = acc − (acc >> SHIFT) + IN. The result never overflows DATA_WIDTH+SHIFT bits, so no saturation is needed on acc.
- Rising edge with RESET=1 and PHASE=1 (phase A):
  - in_reg <= IN_VALUE
  - part <= acc − (acc >> SHIFT)
  - pend <= 1
- Rising edge with RESET=1, PHASE=0 and pend=1 (phase B):
  - acc <= part + in_reg
  - OUT_VALUE <= (part + in_reg) >> SHIFT (truncating; see Configuration)
  - pend <= 0
- PHASE=0 with pend=0: no state change. This prevents a PHASE held low from repeating updates.
- PHASE held 1: phase A repeats every cycle. acc and OUT_VALUE hold, and in_reg tracks IN_VALUE.
- Steady state: for a constant input X held long enough, OUT_VALUE equals X exactly, because truncation leaves acc in [X<<SHIFT, (X<<SHIFT)+2^SHIFT−1].
- Step response: the error decays by a factor (1 − 2^-SHIFT) per update. The time constant is about 2^SHIFT updates.

## Timing
- Reset (RESET=0 at an edge): acc, part, in_reg, pend and OUT_VALUE all clear to 0. This takes precedence over PHASE.
- Reset asserted mid-update (between phase A and phase B) discards the pending update.
- Latency: IN_VALUE sampled at a phase-A edge affects OUT_VALUE at the next phase-B edge, one clock later.
- Throughput: one update per PHASE period (2 clocks nominal).
- OUT_VALUE changes only on phase-B edges or reset. It is stable for at least one full PHASE period.
- IN_VALUE is ignored on all edges except phase-A edges.
- Critical path: one DATA_WIDTH+SHIFT subtractor per phase, one adder per phase.

## Configuration
- Macro FIR_FILTER_OUT_ROUND_EN.
- Defined: phase B computes OUT_VALUE = (acc_next + 2^(SHIFT−1)) >> SHIFT, saturated to all-ones if the result exceeds DATA_WIDTH bits.
- Not defined: OUT_VALUE = acc_next >> SHIFT, truncating.
- acc is identical in both builds; only the output mapping differs.

## Test plan
All cases use defaults (DATA_WIDTH=32, SHIFT=8) with the macro undefined unless noted.
1. Reset: hold RESET=0 for 15 cycles with arbitrary IN_VALUE and PHASE -> OUT_VALUE=0 throughout and on the first cycle after release.
2. First steps: from reset, IN_VALUE=0x12000000 with PHASE toggling -> OUT_VALUE = 0x00120000 after the 1st update, then 0x0023EE00 after the 2nd.
3. Convergence: hold 0x12000000 for 6000 updates -> OUT_VALUE == 0x12000000 exactly. Then step to 0x23000000 -> OUT_VALUE rises monotonically and reaches 0x23000000 exactly.
4. Downward step: from settled 0x45000000 apply 0x15000000 -> OUT_VALUE decreases monotonically, never undershoots, and settles at 0x15000000.
5. PHASE stalls:
   - PHASE held 0 for 100 cycles after a phase-B edge -> no OUT_VALUE change.
   - PHASE held 1 for 100 cycles -> no change; the next PHASE=0 edge performs exactly one update using the last sampled IN_VALUE.
6. Rounding and mid-update reset:
   - With FIR_FILTER_OUT_ROUND_EN and input 0x55000000 from reset -> first OUT_VALUE = 0x00550000.
   - RESET=0 between phase A and phase B -> no update occurs and all state reads 0.

Source files
------------

// File: rtl/fir_filter_stage_k_pow2.sv
// Power-of-two single-pole smoother: y += (x - y) * 2^-SHIFT, split over a PHASE A/B pair.
// Define FIR_FILTER_OUT_ROUND_EN for a rounded, saturated output; acc is identical in both builds.
module fir_filter_stage_k_pow2 #(
   parameter int DATA_WIDTH = 32,
   parameter int SHIFT      = 8
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  PHASE,
   input  logic [DATA_WIDTH-1:0] IN_VALUE,
   output logic [DATA_WIDTH-1:0] OUT_VALUE
);

   localparam int AW = DATA_WIDTH + SHIFT;

   logic [AW-1:0]         acc;
   logic [AW-1:0]         part;
   logic [AW-1:0]         acc_next;
   logic [DATA_WIDTH-1:0] in_reg;
   logic [DATA_WIDTH-1:0] out_next;
   logic                  pend;

   // acc holds y << SHIFT, so this sum cannot exceed AW bits.
   assign acc_next = part + AW'(in_reg);

`ifdef FIR_FILTER_OUT_ROUND_EN
   localparam logic [AW:0] HALF = (AW+1)'(1) << (SHIFT-1);
   logic [DATA_WIDTH:0] rnd_q;

   assign rnd_q    = (DATA_WIDTH+1)'(({1'b0, acc_next} + HALF) >> SHIFT);
   assign out_next = rnd_q[DATA_WIDTH] ? '1 : rnd_q[DATA_WIDTH-1:0];
`else
   assign out_next = acc_next[AW-1:SHIFT];
`endif

   // Phase A samples input and forms acc - acc/2^SHIFT; phase B commits once per A.
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         acc       <= '0;
         part      <= '0;
         in_reg    <= '0;
         pend      <= 1'b0;
         OUT_VALUE <= '0;
      end else if (PHASE) begin
         in_reg <= IN_VALUE;
         part   <= acc - (acc >> SHIFT);
         pend   <= 1'b1;
      end else if (pend) begin
         acc       <= acc_next;
         OUT_VALUE <= out_next;
         pend      <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fir_filter_stage_k_pow2.sv
// Directed bench for fir_filter_stage_k_pow2 at DATA_WIDTH=32, SHIFT=8.
`timescale 1ns/1ps
module tb_fir_filter_stage_k_pow2;

   logic        CLK = 1'b0;
   logic        RESET = 1'b0;
   logic        PHASE = 1'b0;
   logic [31:0] IN_VALUE = '0;
   logic [31:0] OUT_VALUE;

   int          n_vec = 0;
   int          n_err = 0;
   logic [39:0] acc_m = '0;

   fir_filter_stage_k_pow2 #(.DATA_WIDTH(32), .SHIFT(8)) dut (
      .CLK(CLK),
      .RESET(RESET),
      .PHASE(PHASE),
      .IN_VALUE(IN_VALUE),
      .OUT_VALUE(OUT_VALUE)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] model_out(input logic [39:0] a);
`ifdef FIR_FILTER_OUT_ROUND_EN
      logic [40:0] r;
      r = {1'b0, a} + 41'd128;
      return r[40] ? 32'hFFFF_FFFF : r[39:8];
`else
      return a[39:8];
`endif
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // One full A/B update; IN_VALUE is scrambled during phase B since it must be ignored there.
   task automatic update(input logic [31:0] x);
      PHASE    = 1'b1;
      IN_VALUE = x;
      tick();
      acc_m    = acc_m - (acc_m >> 8) + {8'b0, x};
      PHASE    = 1'b0;
      IN_VALUE = $urandom;
      tick();
   endtask

   task automatic do_reset();
      RESET = 1'b0;
      PHASE = 1'b0;
      tick();
      tick();
      RESET = 1'b1;
      acc_m = '0;
   endtask

   task automatic ramp(input string tag, input logic [31:0] target, input bit up, input int bound);
      logic [31:0] prev;
      bit          mono;
      bit          reached;
      prev    = OUT_VALUE;
      mono    = 1'b1;
      reached = 1'b0;
      for (int i = 0; i < bound && !reached; i++) begin
         update(target);
         if (up && (OUT_VALUE < prev || OUT_VALUE > target)) mono = 1'b0;
         if (!up && (OUT_VALUE > prev || OUT_VALUE < target)) mono = 1'b0;
         prev    = OUT_VALUE;
         reached = (OUT_VALUE == target);
      end
      chk({tag, "_mono"}, 32'(mono), 32'd1);
`ifdef FIR_FILTER_OUT_ROUND_EN
      if (up) chk({tag, "_reach"}, OUT_VALUE, target);
`else
      chk({tag, "_reach"}, OUT_VALUE, target);
`endif
      chk({tag, "_model"}, OUT_VALUE, model_out(acc_m));
   endtask

   initial begin
      logic [31:0] held;
      bit          changed;

      // Reset held with noise on PHASE / IN_VALUE
      RESET = 1'b0;
      for (int i = 0; i < 15; i++) begin
         IN_VALUE = $urandom;
         PHASE    = 1'($urandom_range(0, 1));
         tick();
         chk("rst_hold", OUT_VALUE, 32'h0);
      end
      RESET = 1'b1;
      PHASE = 1'b0;
      acc_m = '0;
      tick();
      chk("rst_release", OUT_VALUE, 32'h0);

      // First two updates from zero
      update(32'h1200_0000);
      chk("step1", OUT_VALUE, 32'h0012_0000);
      update(32'h1200_0000);
      chk("step2", OUT_VALUE, 32'h0023_EE00);

      // Convergence, then upward step
      repeat (5998) update(32'h1200_0000);
      chk("conv_12", OUT_VALUE, 32'h1200_0000);
      ramp("up_23", 32'h2300_0000, 1'b1, 8000);

      // Settle at 0x45000000, then downward step
      ramp("up_45", 32'h4500_0000, 1'b1, 8000);
      ramp("down_15", 32'h1500_0000, 1'b0, 8000);

      // PHASE held low after a phase-B edge
      held    = OUT_VALUE;
      changed = 1'b0;
      PHASE   = 1'b0;
      for (int i = 0; i < 100; i++) begin
         IN_VALUE = $urandom;
         tick();
         if (OUT_VALUE !== held) changed = 1'b1;
      end
      chk("ph0_stall", 32'(changed), 32'd0);

      // PHASE held high: in_reg tracks input, output frozen
      PHASE = 1'b1;
      for (int i = 0; i < 100; i++) begin
         IN_VALUE = (i == 99) ? 32'h8000_0000 : $urandom;
         tick();
         if (OUT_VALUE !== held) changed = 1'b1;
      end
      chk("ph1_stall", 32'(changed), 32'd0);
      acc_m = acc_m - (acc_m >> 8) + {8'b0, 32'h8000_0000};
      PHASE = 1'b0;
      IN_VALUE = 32'h0;
      tick();
      chk("ph1_release", OUT_VALUE, model_out(acc_m));
      tick();
      tick();
      chk("single_update", OUT_VALUE, model_out(acc_m));

      // Output mapping of a half-LSB accumulator
      do_reset();
      update(32'h0000_0080);
`ifdef FIR_FILTER_OUT_ROUND_EN
      chk("half_lsb", OUT_VALUE, 32'h1);
      do_reset();
      update(32'h5500_0000);
      chk("round_first", OUT_VALUE, 32'h0055_0000);
`else
      chk("half_lsb", OUT_VALUE, 32'h0);
`endif

      // Reset between phase A and phase B drops the pending update
      do_reset();
      update(32'h1200_0000);
      chk("midrst_pre", OUT_VALUE, 32'h0012_0000);
      PHASE    = 1'b1;
      IN_VALUE = 32'h7700_0000;
      tick();
      RESET = 1'b0;
      PHASE = 1'b0;
      tick();
      chk("midrst_out", OUT_VALUE, 32'h0);
      RESET = 1'b1;
      acc_m = '0;
      tick();
      tick();
      chk("midrst_nopend", OUT_VALUE, 32'h0);
      update(32'h1200_0000);
      chk("midrst_fresh", OUT_VALUE, 32'h0012_0000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
